i2s_rx: RTL and testbench

- I2S receiver (slave) for the audio path.
- Accepts external BCK/LRCK/SD lines, oversamples them on the 100 MHz system clock, and deserializes 16-bit stereo frames into parallel left/right words with a one-cycle valid strobe.
- Consumes the serial stream produced against our I2S bit clock (1.4112 MHz BCK). Used for ADC input and for loopback checking of the DAC transmit path.

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_sync_edge.sv | 36 +++
 rtl/i2s_rx.sv | 165 ++++++++++++++++
 tb/tb_i2s_rx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and FSM state type for the I2S receiver.
// Word width and channel encoding live here so top and bench agree.
package i2s_pkg;
  localparam int I2S_DATA_WIDTH = 16;
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    UNLOCKED,
    DELAY,
    SHIFT,
    HOLD
  } state_t;
endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchronizer for the async I2S lines.
// The strobe source also yields a one-cycle rising-edge pulse.
module i2s_sync_edge
  import i2s_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src,
  input  logic [WIDTH-1:0] d,
  output logic             rise,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0]            src_pipe;
  logic                         src_prev;
  logic [STAGES-1:0][WIDTH-1:0] d_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      src_pipe <= '0;
      src_prev <= 1'b0;
      d_pipe   <= '0;
    end else begin
      src_pipe <= {src_pipe[STAGES-2:0], src};
      src_prev <= src_pipe[STAGES-1];
      d_pipe   <= {d_pipe[STAGES-2:0], d};
    end
  end

  assign rise = src_pipe[STAGES-1] & ~src_prev;
  assign q    = d_pipe[STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: 16-bit stereo deserializer with pair strobe.
// Define I2S_RX_LJ_EN for left-justified framing (no one-bit delay).
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = I2S_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bck_i,
  input  logic                  lrck_i,
  input  logic                  sd_i,
  output logic [DATA_WIDTH-1:0] left_o,
  output logic [DATA_WIDTH-1:0] right_o,
  output logic                  valid_o,
  output logic                  frame_err_o,
  output logic                  locked_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
`ifdef I2S_RX_LJ_EN
  localparam bit            LJ    = 1'b1;
  localparam logic [CW-1:0] START = CW'(1);
  localparam state_t        ENTRY = SHIFT;
`else
  localparam bit            LJ    = 1'b0;
  localparam logic [CW-1:0] START = '0;
  localparam state_t        ENTRY = DELAY;
`endif

  logic [1:0] lines;
  logic bck_rise, lrck, sd;

  i2s_sync_edge #(
    .WIDTH (2),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .src  (bck_i),
    .d    ({lrck_i, sd_i}),
    .rise (bck_rise),
    .q    (lines)
  );

  assign lrck = lines[1];
  assign sd   = lines[0];

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] shreg, left_hold, word;
  logic lr_prev, primed, channel, left_ok;
  logic lr_edge, shift_en, restart, done, short_word;

  assign lr_edge = bck_rise && primed && (lrck != lr_prev);
  assign word    = {shreg[DATA_WIDTH-2:0], sd};

  always_ff @(posedge clk) begin
    if (reset) state <= UNLOCKED;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shift_en   = 1'b0;
    restart    = 1'b0;
    done       = 1'b0;
    short_word = 1'b0;
    if (bck_rise) begin
      unique case (state)
        UNLOCKED, HOLD: begin
          if (lr_edge) begin
            restart  = 1'b1;
            state_n  = ENTRY;
            cnt_n    = START;
            shift_en = LJ;
          end
        end
        DELAY: begin
          if (lr_edge) begin
            restart = 1'b1;
            cnt_n   = '0;
          end else begin
            state_n  = SHIFT;
            shift_en = 1'b1;
            cnt_n    = CW'(1);
          end
        end
        SHIFT: begin
          if (!lr_edge) begin
            shift_en = 1'b1;
            cnt_n    = cnt + CW'(1);
            if (cnt == LAST) begin
              done    = 1'b1;
              state_n = HOLD;
            end
          end else begin
            restart  = 1'b1;
            state_n  = ENTRY;
            cnt_n    = START;
            shift_en = LJ;
            // I2S puts the LSB on the first bck of the next slot
            if (!LJ && cnt == LAST) begin
              shift_en = 1'b1;
              done     = 1'b1;
            end else begin
              short_word = 1'b1;
            end
          end
        end
        default: state_n = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      shreg       <= '0;
      left_hold   <= '0;
      lr_prev     <= 1'b0;
      primed      <= 1'b0;
      channel     <= CH_LEFT;
      left_ok     <= 1'b0;
      left_o      <= '0;
      right_o     <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      locked_o    <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      cnt         <= cnt_n;
      if (bck_rise) begin
        primed  <= 1'b1;
        lr_prev <= lrck;
      end
      if (shift_en) shreg <= word;
      if (restart) begin
        channel <= lrck;
        if (lrck == CH_LEFT) left_ok <= 1'b0;
      end
      if (short_word) begin
        frame_err_o <= 1'b1;
        if (channel == CH_LEFT) left_ok <= 1'b0;
      end
      if (done) begin
        if (channel == CH_LEFT) begin
          left_hold <= word;
          left_ok   <= 1'b1;
        end else if (channel == CH_RIGHT && left_ok) begin
          left_o   <= left_hold;
          right_o  <= word;
          valid_o  <= 1'b1;
          locked_o <= 1'b1;
          left_ok  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: slot-level stream builder, frame model, event compare.
// Honours I2S_RX_LJ_EN to match the receiver framing under test.
module tb_i2s_rx;

  localparam int DW   = 16;
  localparam int HALF = 35;
`ifdef I2S_RX_LJ_EN
  localparam bit RX_LJ = 1'b1;
`else
  localparam bit RX_LJ = 1'b0;
`endif
  localparam int RXD = RX_LJ ? 0 : 1;
  localparam bit TXD = !RX_LJ;

  logic clk = 1'b0;
  logic reset, bck_i, lrck_i, sd_i;
  logic [DW-1:0] left_o, right_o;
  logic valid_o, frame_err_o, locked_o;

  i2s_rx dut (
    .clk        (clk),
    .reset      (reset),
    .bck_i      (bck_i),
    .lrck_i     (lrck_i),
    .sd_i       (sd_i),
    .left_o     (left_o),
    .right_o    (right_o),
    .valid_o    (valid_o),
    .frame_err_o(frame_err_o),
    .locked_o   (locked_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        err;
    logic [15:0] l;
    logic [15:0] r;
  } ev_t;

  bit lr[$];
  bit sdq[$];
  bit carry;
  ev_t exp_q[$];
  ev_t exp_all[$];
  logic [15:0] gl[$];
  logic [15:0] gr[$];
  int tests = 0;
  int fails = 0;
  logic [15:0] hl, hr;
  bit lk;
  bit run_chk = 1'b0;
  ev_t e;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endfunction

  // One slot: MSB-first word, padded with fill; dly shifts data one bck late
  function automatic void add_slot(bit ch, int len, logic [15:0] w, bit fill, bit dly);
    bit b[$];
    for (int p = 0; p < len; p++) b.push_back(p < 16 ? w[15-p] : fill);
    for (int p = 0; p < len; p++) begin
      lr.push_back(ch);
      sdq.push_back(dly ? (p == 0 ? carry : b[p-1]) : b[p]);
    end
    carry = b[len-1];
  endfunction

  // Frame-level expectation: slots are spans between lrck changes
  function automatic void model(int a, int b);
    int edges[$];
    int s, len;
    bit ch, lok;
    logic [15:0] lh, w;
    ev_t ev;
    for (int n = a + 1; n < b; n++)
      if (lr[n] != lr[n-1]) edges.push_back(n);
    lok = 0;
    lh  = '0;
    for (int i = 0; i + 1 < edges.size(); i++) begin
      s   = edges[i];
      len = edges[i+1] - s;
      ch  = lr[s];
      if (len < DW) begin
        ev.err = 1; ev.l = '0; ev.r = '0;
        exp_q.push_back(ev);
        if (ch == 0) lok = 0;
      end else begin
        w = '0;
        for (int k = 0; k < DW; k++) w = {w[14:0], sdq[s+RXD+k]};
        if (ch == 0) begin
          lh  = w;
          lok = 1;
        end else begin
          if (lok) begin
            ev.err = 0; ev.l = lh; ev.r = w;
            exp_q.push_back(ev);
          end
          lok = 0;
        end
      end
    end
  endfunction

  function automatic void pin_ev(int i, bit err, logic [15:0] l, logic [15:0] r);
    tests++;
    if (exp_all.size() <= i) begin
      fails++;
      $display("FAIL model_ev%0d missing size=%0d", i, exp_all.size());
    end else if (exp_all[i].err != err || exp_all[i].l !== l || exp_all[i].r !== r) begin
      fails++;
      $display("FAIL model_ev%0d got=%b/%h/%h want=%b/%h/%h", i,
               exp_all[i].err, exp_all[i].l, exp_all[i].r, err, l, r);
    end
  endfunction

  function automatic void pin_dut(int i, logic [15:0] l, logic [15:0] r);
    tests++;
    if (gl.size() <= i) begin
      fails++;
      $display("FAIL dut_pair%0d missing count=%0d", i, gl.size());
    end else if (gl[i] !== l || gr[i] !== r) begin
      fails++;
      $display("FAIL dut_pair%0d got=%h/%h want=%h/%h", i, gl[i], gr[i], l, r);
    end
  endfunction

  task automatic send(int a, int b);
    for (int n = a; n < b; n++) begin
      lrck_i = lr[n];
      sd_i   = sdq[n];
      bck_i  = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
      bck_i = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      if (valid_o || frame_err_o) begin
        tests++;
        if (valid_o && frame_err_o) begin
          fails++;
          $display("FAIL both_pulses valid=1 err=1 want exclusive");
        end else if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_event valid=%b err=%b want none", valid_o, frame_err_o);
        end else begin
          e = exp_q.pop_front();
          if (valid_o) begin
            gl.push_back(left_o);
            gr.push_back(right_o);
            if (e.err || left_o !== e.l || right_o !== e.r || locked_o !== 1'b1) begin
              fails++;
              $display("FAIL pair got=%h/%h lock=%b want err=%b %h/%h lock=1",
                       left_o, right_o, locked_o, e.err, e.l, e.r);
            end
            hl = e.l;
            hr = e.r;
            lk = 1'b1;
          end else if (!e.err) begin
            fails++;
            $display("FAIL event_type got frame_err want pair %h/%h", e.l, e.r);
          end
        end
      end else begin
        tests++;
        if (left_o !== hl || right_o !== hr || locked_o !== lk) begin
          fails++;
          $display("FAIL hold got=%h/%h/%b want=%h/%h/%b",
                   left_o, right_o, locked_o, hl, hr, lk);
        end
      end
      if (reset) begin
        hl = '0;
        hr = '0;
        lk = 1'b0;
      end
    end
  end

  initial begin
    int s15, end_a, start_b, end_b;
    reset  = 1'b1;
    bck_i  = 1'b0;
    lrck_i = 1'b1;
    sd_i   = 1'b0;
    hl = '0;
    hr = '0;
    lk = 1'b0;
    carry = 1'b0;

    add_slot(1, 7, 16'h3C3C, 0, TXD);
    add_slot(0, 16, 16'h7FFF, 0, TXD);
    add_slot(1, 16, 16'h8000, 0, TXD);
    add_slot(0, 16, 16'hA5C3, 0, TXD);
    add_slot(1, 16, 16'h1234, 0, TXD);
    add_slot(0, 32, 16'h0F0F, 1, TXD);
    add_slot(1, 32, 16'hF0F0, 1, TXD);
    add_slot(0, 10, 16'h3333, 0, TXD);
    add_slot(1, 16, 16'h5555, 0, TXD);
    add_slot(0, 16, 16'h1111, 0, TXD);
    add_slot(1, 16, 16'h2222, 0, TXD);
    add_slot(0, 16, 16'h0000, 0, TXD);
    add_slot(1, 16, 16'h0000, 0, TXD);
    add_slot(0, 16, 16'h8001, 0, 0);
    add_slot(1, 16, 16'h4002, 0, 0);
    s15 = lr.size();
    add_slot(0, 16, 16'h0000, 0, 0);
    end_a   = s15 + 8;
    start_b = lr.size();
    model(0, end_a);
    add_slot(0, 8, 16'h0000, 0, TXD);
    add_slot(1, 16, 16'h7777, 0, TXD);
    add_slot(0, 16, 16'hBEEF, 0, TXD);
    add_slot(1, 16, 16'hCAFE, 0, TXD);
    add_slot(0, 16, 16'h0000, 0, TXD);
    end_b = lr.size();
    model(start_b, end_b);
    exp_all = exp_q;

    pin_ev(0, 0, 16'h7FFF, 16'h8000);
    pin_ev(1, 0, 16'hA5C3, 16'h1234);
    pin_ev(2, 0, 16'h0F0F, 16'hF0F0);
    pin_ev(3, 1, 16'h0000, 16'h0000);
    pin_ev(4, 0, 16'h1111, 16'h2222);
    pin_ev(5, 0, 16'h0000, RX_LJ ? 16'h0000 : 16'h0001);
    pin_ev(6, 0, RX_LJ ? 16'h8001 : 16'h0002, RX_LJ ? 16'h4002 : 16'h8004);
    pin_ev(7, 0, 16'hBEEF, 16'hCAFE);
    chk("model_count", exp_all.size(), 8);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_left", left_o, 0);
    chk("rst_right", right_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_err", frame_err_o, 0);
    chk("rst_locked", locked_o, 0);
    run_chk = 1'b1;

    send(0, end_a);
    chk("locked_before_reset", locked_o, 1);
    bck_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midword_rst_left", left_o, 0);
    chk("midword_rst_right", right_o, 0);
    chk("midword_rst_locked", locked_o, 0);

    send(start_b, end_b);
    repeat (200) @(posedge clk);
    run_chk = 1'b0;

    chk("pending_events", exp_q.size(), 0);
    chk("pair_count", gl.size(), 7);
    pin_dut(0, 16'h7FFF, 16'h8000);
    pin_dut(1, 16'hA5C3, 16'h1234);
    pin_dut(2, 16'h0F0F, 16'hF0F0);
    pin_dut(3, 16'h1111, 16'h2222);
    pin_dut(5, RX_LJ ? 16'h8001 : 16'h0002, RX_LJ ? 16'h4002 : 16'h8004);
    pin_dut(6, 16'hBEEF, 16'hCAFE);
    chk("final_locked", locked_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
